// File: rtl/sqrt_job_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// sqrt_job_sequencer_pkg : shared FSM state type and widths for the sequencer
// Rev 1.0
// ============================================================================
package sqrt_job_sequencer_pkg;

  localparam int LAUNCH_CYCLES    = 2;
  localparam int STOP_MASK_CYCLES = 1;
  localparam int SQRT_RESULT_W    = 24;
  localparam int RADICAND_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_in_fifo.sv
`default_nettype none
// ============================================================================
// sqrt_in_fifo : power-of-two job FIFO, extra pointer bit separates full/empty
// Rev 1.0
// ============================================================================
module sqrt_in_fifo
  import sqrt_job_sequencer_pkg::*;
#(
  parameter int WIDTH = RADICAND_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/sqrt_job_sequencer.sv
`default_nettype none
// ============================================================================
// sqrt_job_sequencer : queues radicands, drives a sqrt unit, retries timeouts
// Rev 1.0
// ============================================================================
module sqrt_job_sequencer
  import sqrt_job_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32,
  parameter int MAX_RETRY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [RADICAND_W-1:0]    in_data_i,
  output logic                     sq_start_o,
  output logic [RADICAND_W-1:0]    sq_num_o,
  input  logic [SQRT_RESULT_W-1:0] sq_result_i,
  input  logic                     sq_stop_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [SQRT_RESULT_W-1:0] out_data_o,
  output logic                     out_err_o,
  output logic                     busy_o,
  output logic [7:0]               err_count_o
);

  localparam int CNT_W   = $clog2(TIMEOUT + LAUNCH_CYCLES);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   LAUNCH_LAST = CNT_W'(LAUNCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   MASK_END    = CNT_W'(STOP_MASK_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  state_e                   state_q,  state_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  logic [RETRY_W-1:0]       retry_q,  retry_d;
  logic [RADICAND_W-1:0]    job_q,    job_d;
  logic [SQRT_RESULT_W-1:0] data_q,   data_d;
  logic                     err_q,    err_d;
  logic [7:0]               errcnt_q, errcnt_d;

  logic                     w_fifo_push;
  logic                     w_fifo_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [RADICAND_W-1:0]    w_fifo_rdata;

  assign in_ready_o  = ~w_fifo_full | w_fifo_pop;
  assign w_fifo_push = in_valid_i & in_ready_o;

  sqrt_in_fifo #(
    .WIDTH (RADICAND_W),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_fifo_push),
    .pop_i   (w_fifo_pop),
    .wdata_i (in_data_i),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      job_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      job_q    <= job_d;
      data_q   <= data_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    job_d      = job_q;
    data_d     = data_q;
    err_d      = err_q;
    errcnt_d   = errcnt_q;
    w_fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          job_d      = w_fifo_rdata;
          retry_d    = '0;
          cnt_d      = '0;
          state_d    = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        if (cnt_q == LAUNCH_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT: begin
        // The first WAIT cycle may still see Stop left over from the previous job.
        if (sq_stop_i && (cnt_q >= MASK_END)) begin
          data_d  = sq_result_i;
          err_d   = 1'b0;
          state_d = ST_HOLD;
        end else if (cnt_q == WAIT_LAST) begin
          errcnt_d = sat_inc8(errcnt_q);
          cnt_d    = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_LAUNCH;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (out_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sq_start_o  = (state_q == ST_LAUNCH);
  assign sq_num_o    = job_q;
  assign out_valid_o = (state_q == ST_HOLD);
  assign out_data_o  = data_q;
  assign out_err_o   = err_q;
  assign busy_o      = (state_q != ST_IDLE) | ~w_fifo_empty;
  assign err_count_o = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_job_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sqrt_job_sequencer : directed bench with a queue-based result model
// Rev 1.0
// ============================================================================
module tb_sqrt_job_sequencer;
  import sqrt_job_sequencer_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 32;
  localparam int MAX_RETRY  = 1;
  // accept -> pop is one cycle, pop -> out_valid is 28 (nominal) or 69 (dead unit)
  localparam int NOM_LAT    = 1 + LAUNCH_CYCLES + STOP_MASK_CYCLES + 24 + 1;
  localparam int DEAD_LAT   = 1 + (MAX_RETRY + 1) * (LAUNCH_CYCLES + TIMEOUT) + 1;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        sq_start, sq_stop;
  logic [31:0] sq_num;
  logic [23:0] sq_result;
  logic        out_valid, out_ready, out_err, busy;
  logic [23:0] out_data;
  logic [7:0]  err_count;

  sqrt_job_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .sq_start_o  (sq_start),
    .sq_num_o    (sq_num),
    .sq_result_i (sq_result),
    .sq_stop_i   (sq_stop),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_err_o   (out_err),
    .busy_o      (busy),
    .err_count_o (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_n  = 0;
  int miss_n = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] isqrt_q8(input logic [31:0] x);
    longint unsigned v, lo, hi, mid;
    v  = {16'h0, x, 16'h0};
    lo = 0;
    hi = 64'd1 << 24;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= v) lo = mid;
      else                hi = mid;
    end
    return lo[23:0];
  endfunction

  // Square-root unit: Stop rises 24 cycles after Start falls and then stays high.
  logic        dead, glitch;
  logic        m_run, m_stop;
  int          m_cnt;
  logic [31:0] m_num;
  logic [23:0] m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_stop <= 1'b0; m_cnt <= 0; m_num <= '0; m_res <= '0;
    end else if (sq_start) begin
      m_run <= 1'b1; m_cnt <= 0; m_num <= sq_num;
    end else if (m_run) begin
      if (m_cnt == 23) begin
        m_stop <= 1'b1; m_res <= isqrt_q8(m_num); m_run <= 1'b0;
      end else begin
        m_stop <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end
  assign sq_stop   = dead ? 1'b0 : (m_stop | glitch);
  assign sq_result = glitch ? 24'hABCDEF : m_res;

  // Expected-result model and the single compare process
  typedef struct packed {
    logic [23:0] d;
    logic        e;
    logic [7:0]  ec;
  } exp_t;
  exp_t        expq[$];
  exp_t        ex, got;
  logic [23:0] out_log[$];
  int          cum_err = 0;
  int          acc_cyc = 0, rise_cyc = 0, start_run = 0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
  logic [23:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      cum_err    = 0;
      start_run  = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (dead) begin
          cum_err = cum_err + MAX_RETRY + 1;
          if (cum_err > 255) cum_err = 255;
          ex.d = '0;
          ex.e = 1'b1;
        end else begin
          ex.d = isqrt_q8(in_data);
          ex.e = 1'b0;
        end
        ex.ec = 8'(cum_err);
        expq.push_back(ex);
        acc_cyc = cyc;
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid && prev_valid && !prev_ready) begin
        chk("hold_data_stable", out_data, prev_data);
        chk("hold_err_stable", out_err, prev_err);
      end
      if (out_valid) chk("start_during_hold", sq_start, 1'b0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", out_valid, 1'b0);
        end else begin
          got = expq.pop_front();
          chk("out_data", out_data, got.d);
          chk("out_err", out_err, got.e);
          chk("err_count_at_out", err_count, got.ec);
          out_log.push_back(out_data);
        end
      end
      if (sq_start) begin
        start_run++;
      end else begin
        if (start_run != 0) chk("start_pulse_len", start_run, LAUNCH_CYCLES);
        start_run = 0;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_err   = out_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [31:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_pending", expq.size(), 0);
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sq_start", sq_start, 1'b0);
    chk("rst_sq_num", sq_num, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 24'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_err_count", err_count, 8'h0);
    chk("rst_busy", busy, 1'b0);
  endtask

  logic [31:0] fillv [8] = '{32'd100, 32'd200, 32'd300, 32'd400,
                             32'd500, 32'd600, 32'd700, 32'd800};

  initial begin
    int base, idx, acc, n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    dead = 1'b0; glitch = 1'b0;
    #1;
    chk("async_rst_start", sq_start, 1'b0);
    chk("async_rst_valid", out_valid, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    check_reset_values();
    tick();

    // Single job, nominal latency and value
    base = out_log.size();
    send_job(32'd16);
    wait_drain();
    chk("lat_nominal", rise_cyc - acc_cyc, NOM_LAT);
    chk("n_out_single", out_log.size(), base + 1);
    if (out_log.size() > base) chk("sqrt_16", out_log[base], 24'h000400);

    // Back-to-back extremes; later jobs launch with stale Stop still high
    base = out_log.size();
    send_job(32'd0);
    send_job(32'hFFFF_FFFF);
    send_job(32'd2);
    wait_drain();
    chk("n_out_b2b", out_log.size(), base + 3);
    if (out_log.size() >= base + 3) begin
      chk("sqrt_0", out_log[base], 24'h000000);
      chk("sqrt_max", out_log[base + 1], 24'hFFFFFF);
      chk("sqrt_2", out_log[base + 2], 24'h00016A);
    end

    // Backpressure: four in the FIFO plus one in the job register
    base      = out_log.size();
    out_ready = 1'b0;
    idx       = 0;
    acc       = 0;
    in_valid  = 1'b1;
    in_data   = fillv[0];
    repeat (10) begin
      @(negedge clk);
      if (in_ready) begin acc++; idx++; end
      @(posedge clk);
      #1;
      in_data = fillv[idx];
    end
    chk("fill_accepted", acc, FIFO_DEPTH + 1);
    chk("fill_in_ready", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("fill_n_out", out_log.size(), base + FIFO_DEPTH + 1);

    // Stop/result glitches while holding a result and while idle
    out_ready = 1'b0;
    send_job(32'd9);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("glitch_reach_hold", out_valid, 1'b1);
    glitch = 1'b1;
    repeat (3) tick();
    glitch = 1'b0;
    tick();
    chk("glitch_hold_data", out_data, 24'h000300);
    chk("glitch_hold_err", out_err, 1'b0);
    out_ready = 1'b1;
    wait_drain();
    glitch = 1'b1;
    repeat (3) tick();
    chk("glitch_idle_busy", busy, 1'b0);
    chk("glitch_idle_valid", out_valid, 1'b0);
    glitch = 1'b0;
    tick();

    // Reset while waiting on the unit with two jobs buffered
    send_job(32'd25);
    send_job(32'd36);
    send_job(32'd49);
    repeat (6) tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sq_start", sq_start, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sq_num", sq_num, 32'h0);
    base = out_log.size();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values();
    repeat (100) tick();
    chk("no_out_after_rst", out_log.size(), base);
    chk("idle_after_rst", busy, 1'b0);

    // Dead unit: two launches then an error result
    dead = 1'b1;
    send_job(32'd77);
    wait_drain();
    chk("lat_timeout", rise_cyc - acc_cyc, DEAD_LAT);
    chk("err_count_two", err_count, 8'd2);

    // Enough dead jobs to push the error counter past its ceiling
    for (int i = 0; i < 130; i++) send_job(32'(i));
    wait_drain();
    chk("err_count_sat", err_count, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sqrt_job_sequencer.md
SQRT_JOB_SEQUENCER -- requirements
Module: sqrt_job_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input job buffer depth (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 32, max cycles waited for sq_stop after launch.
REQ-003 Parameter MAX_RETRY, default 1, relaunches allowed per job after a timeout.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream job offered.
REQ-007 in_ready  output  1  sequencer accepts job; transfer when in_valid & in_ready.
REQ-008 in_data  input  32  unsigned radicand.
REQ-009 sq_start  output  1  drives Start of the square-root unit.
REQ-010 sq_num  output  32  drives InpNum of the square-root unit.
REQ-011 sq_result  input  24  Result of the square-root unit, sqrt(x)*256 (Q16.8).
REQ-012 sq_stop  input  1  Stop of the square-root unit.
REQ-013 out_valid  output  1  result available downstream.
REQ-014 out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-015 out_data  output  24  captured result (Q16.8).
REQ-016 out_err  output  1  result invalid: all retries timed out.
REQ-017 busy  output  1  FSM not in IDLE or FIFO non-empty.
REQ-018 err_count  output  8  saturating count of timeout events (every timeout, including retried ones).

Function
REQ-019 SHALL buffer accepted jobs in a FIFO_DEPTH-entry FIFO; in_ready = !full; accept in the same cycle as a pop when full.
REQ-020 FSM states SHALL be IDLE, LAUNCH, WAIT, HOLD.
REQ-021 IDLE: FIFO non-empty -> pop head into job register, retry counter = 0, go LAUNCH.
REQ-022 LAUNCH: sq_start = 1 for exactly 2 cycles, sq_num = job register (held stable through WAIT), then WAIT.
REQ-023 WAIT: sq_stop SHALL be ignored during the first cycle after LAUNCH (stale Stop from prior job).
REQ-024 WAIT: sq_stop = 1 (from the second cycle) -> capture sq_result into out_data, out_err = 0, go HOLD.
REQ-025 WAIT: TIMEOUT cycles without qualified sq_stop -> increment err_count; retry < MAX_RETRY -> retry+1, go LAUNCH; else out_data = 0, out_err = 1, go HOLD.
REQ-026 HOLD: out_valid = 1, out_data/out_err stable until out_ready; on transfer go IDLE (next job launches the following cycle at earliest).
REQ-027 Nominal latency: pop to out_valid = 2 + 1 + 24 + 1 cycles = 28 cycles for a conforming sqrt unit (Stop 24 cycles after Start falls).
REQ-028 Results SHALL leave in acceptance order; exactly one output per accepted job.
REQ-029 sq_start SHALL be 0 in IDLE, WAIT, HOLD; out_valid 0 outside HOLD.
REQ-030 err_count SHALL saturate at 255, never wrap.
REQ-031 sq_stop glitches in IDLE/HOLD/LAUNCH SHALL have no effect.

Reset
REQ-032 rst SHALL asynchronously force: FSM IDLE, FIFO empty, in_ready 1 (after release), sq_start 0, sq_num 0, out_valid 0, out_data 0, out_err 0, err_count 0, busy 0.
REQ-033 rst mid-job SHALL discard in-flight and buffered jobs; no output is produced for them.
REQ-034 First launch after reset SHALL occur no earlier than the second cycle after rst deasserts with a job present.

Structure
REQ-035 Shared package SHALL hold the FSM state enum, LAUNCH_CYCLES = 2, STOP_MASK_CYCLES = 1, SQRT_RESULT_W = 24, RADICAND_W = 32.
REQ-036 FIFO SHALL be a separate sub-module sqrt_in_fifo (parameterised width/depth, full/empty flags, pointer wrap at FIFO_DEPTH).

Verification
REQ-037 Single job in_data = 16 with real sqrt unit, out_ready = 1 -> out_data = 0x000400, out_err = 0, out_valid 28 cycles after pop.
REQ-038 Jobs 0, 0xFFFFFFFF, 2 back-to-back -> outputs in order 0x000000, 0xFFFFFF, 0x00016A; out_err = 0.
REQ-039 5 jobs offered with out_ready = 0 and FIFO_DEPTH = 4 -> in_ready drops after 4 in FIFO + 1 in job register; no loss after out_ready = 1.
REQ-040 sq_stop tied 0 -> two launches, err_count = 2, out_valid with out_data = 0, out_err = 1 after 2*(2+TIMEOUT)+1 cycles.
REQ-041 sq_stop held 1 from previous job -> masked cycle ignored; capture only on the qualified cycle (model Stop low for 23 cycles, then high).
REQ-042 rst asserted in WAIT with 2 buffered jobs -> sq_start 0 and out_valid 0 immediately; no output emitted afterwards; busy 0.
